// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small transmit FIFO.
//
// The host queues words with i_Tx_DV and the serialiser sends them as
// start / data (LSB first) / optional parity / stop frames. Frames are sent
// back-to-back: when a word is waiting at the end of a stop period, the next
// start bit follows on the very next clock.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      asynchronous active-high reset; abandons any frame in flight
//   i_Tx_DV      write strobe, accepted only while o_Tx_Ready is high
//   i_Tx_Byte    word to queue (DATA_BITS wide)
//   o_Tx_Ready   FIFO not full
//   o_Fifo_Count words waiting in the FIFO (frame in flight not included)
//   o_Tx_Active  a frame is on the line
//   o_Tx_Serial  serial line, idle high
//   o_Tx_Done    one-cycle pulse during the final clock of each frame
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              i_Clock,
  input  logic                              i_Reset,
  input  logic                              i_Tx_DV,
  input  logic [DATA_BITS-1:0]              i_Tx_Byte,
  output logic                              o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count,
  output logic                              o_Tx_Active,
  output logic                              o_Tx_Serial,
  output logic                              o_Tx_Done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_PENULT = BIT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Parity bit that completes the word: odd mode makes the total count of
  // ones odd, even mode makes it even.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    if (PARITY == 1) return ~(^word);
    return ^word;
  endfunction

  // FIFO storage and control
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Serialiser state
  state_t               state_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_q;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_end;
  logic [DATA_BITS-1:0] head;

  assign o_Tx_Ready   = (count_q < DEPTH_C);
  assign o_Fifo_Count = count_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Done    = done_q;

  assign head      = mem_q[rd_ptr_q];
  assign bit_end   = (bit_cnt_q == BIT_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end && (stop_q == STOP_LAST);
  assign push      = i_Tx_DV && o_Tx_Ready;
  // A word leaves the FIFO either from idle or in the last stop clock, so the
  // next start bit needs no idle gap.
  assign pop       = (count_q != '0) && ((state_q == S_IDLE) || frame_end);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
  end

  // Popped word and its parity are captured once so the frame is unaffected
  // by later writes.
  always_ff @(posedge i_Clock) begin
    if (pop) begin
      data_q <= head;
      par_q  <= parity_of(head);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= '0;
          serial_q  <= 1'b1;
          if (pop) begin
            state_q  <= S_START;
            serial_q <= 1'b0;
            active_q <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            idx_q     <= '0;
            serial_q  <= data_q[0];
            state_q   <= S_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              if (PARITY != 0) begin
                serial_q <= par_q;
                state_q  <= S_PARITY;
              end else begin
                serial_q <= 1'b1;
                stop_q   <= 1'b0;
                state_q  <= S_STOP;
              end
            end else begin
              idx_q    <= idx_q + IDX_W'(1);
              serial_q <= data_q[idx_q + IDX_W'(1)];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            serial_q  <= 1'b1;
            stop_q    <= 1'b0;
            state_q   <= S_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        S_STOP: begin
          // Raise Done so that it is visible during the final stop clock.
          if ((stop_q == STOP_LAST) && (bit_cnt_q == BIT_PENULT)) done_q <= 1'b1;
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (stop_q == STOP_LAST) begin
              stop_q <= 1'b0;
              if (pop) begin
                serial_q <= 1'b0;
                state_q  <= S_START;
              end else begin
                active_q <= 1'b0;
                state_q  <= S_IDLE;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          serial_q <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitters sharing one write bus, each with a
// different frame format (8N1, 8O1, 8E1, 7N2), all at 4 clocks per bit and
// a 4-entry FIFO. Each instance has a frame-level reference model: a queue of
// accepted words and the current frame held as an array of line bits.
module tb_uart_tx_fifo;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  logic [3:0]      act_ser, act_done, act_act, act_rdy;
  logic [3:0][2:0] act_cnt;
  logic [3:0]      exp_ser, exp_done, exp_act, exp_rdy;
  logic [3:0][2:0] exp_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : G
    localparam int P_DB  = (g == 3) ? 7 : 8;
    localparam int P_PAR = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int P_SB  = (g == 3) ? 2 : 1;

    uart_tx_fifo #(
      .CLKS_PER_BIT(CLKS),
      .DATA_BITS   (P_DB),
      .PARITY      (P_PAR),
      .STOP_BITS   (P_SB),
      .FIFO_DEPTH  (DEPTH)
    ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Tx_DV     (tx_dv),
      .i_Tx_Byte   (tx_byte[P_DB-1:0]),
      .o_Tx_Ready  (act_rdy[g]),
      .o_Fifo_Count(act_cnt[g]),
      .o_Tx_Active (act_act[g]),
      .o_Tx_Serial (act_ser[g]),
      .o_Tx_Done   (act_done[g])
    );

    int          mq[$];
    bit          busy = 1'b0;
    bit          ended;
    int          t, flen, w, k, ones, sz0;
    logic [15:0] fb;
    logic        e_ser, e_act, e_done, e_rdy;
    logic [2:0]  e_cnt;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mq.delete();
        busy = 1'b0;
        t    = 0;
      end else begin
        sz0   = mq.size();
        ended = busy && (t == flen - 1);
        if (busy && !ended) begin
          t++;
        end else if (sz0 > 0) begin
          w  = mq.pop_front();
          fb = '1;
          fb[0] = 1'b0;
          for (int i = 0; i < P_DB; i++) fb[1+i] = w[i];
          k = 1 + P_DB;
          if (P_PAR != 0) begin
            ones  = $countones(w);
            fb[k] = (P_PAR == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            k++;
          end
          flen = (k + P_SB) * CLKS;
          busy = 1'b1;
          t    = 0;
        end else begin
          busy = 1'b0;
        end
        if (tx_dv && sz0 < DEPTH) mq.push_back(int'(tx_byte) & ((1 << P_DB) - 1));
      end
      e_ser  = busy ? fb[t / CLKS] : 1'b1;
      e_act  = busy;
      e_done = busy && (t == flen - 1);
      e_cnt  = 3'(mq.size());
      e_rdy  = (mq.size() < DEPTH);
    end

    assign exp_ser[g]  = e_ser;
    assign exp_act[g]  = e_act;
    assign exp_done[g] = e_done;
    assign exp_rdy[g]  = e_rdy;
    assign exp_cnt[g]  = e_cnt;
  end

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk("serial", i, 64'(act_ser[i]),  64'(exp_ser[i]));
        chk("active", i, 64'(act_act[i]),  64'(exp_act[i]));
        chk("done",   i, 64'(act_done[i]), 64'(exp_done[i]));
        chk("ready",  i, 64'(act_rdy[i]),  64'(exp_rdy[i]));
        chk("count",  i, 64'(act_cnt[i]),  64'(exp_cnt[i]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] trs [4];
  logic [63:0] trd [4];
  logic [63:0] tra [4];

  // One write, then record 48 line/done/active samples per instance, where
  // sample 0 is the first clock of the frame.
  task automatic send_and_capture(input logic [7:0] b);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick();
    tx_dv = 1'b0;
    for (int t = 0; t < 48; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        trs[i][t] = act_ser[i];
        trd[i][t] = act_done[i];
        tra[i][t] = act_act[i];
      end
    end
    repeat (4) tick();
  endtask

  task automatic wait_done0(input int lim, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < lim && !ok; n++) begin
      tick();
      if (act_done[0] === 1'b1) ok = 1'b1;
    end
  endtask

  int n_done0, n_done1, n_act0, n_act1, n_hi0;
  bit ok;

  initial begin
    fork
      compare_loop();
    join_none

    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_serial", 0, 64'(act_ser[0]), 64'd1);
    chk("rst_ready",  0, 64'(act_rdy[0]), 64'd1);
    chk("rst_count",  0, 64'(act_cnt[0]), 64'd0);
    chk("rst_active", 0, 64'(act_act[0]), 64'd0);
    chk("rst_done",   0, 64'(act_done[0]), 64'd0);

    // Single frames: 0x55 on every format.
    send_and_capture(8'h55);
    chk("t1_line",   0, 64'(trs[0][39:0]), 64'h00F0F0F0F0F0);
    chk("t1_done",   0, trd[0][47:0],       64'h008000000000);
    chk("t1_idle",   0, 64'(tra[0][47:40]), 64'h0);
    chk("t1_line",   1, 64'(trs[1][43:0]), 64'h0FF0F0F0F0F0);
    chk("t1_line",   2, 64'(trs[2][43:0]), 64'h0F00F0F0F0F0);
    chk("t1_line",   3, 64'(trs[3][39:0]), 64'h00FFF0F0F0F0);

    // Parity of 0x03: odd mode sends 1, even mode sends 0; 44-clock frame.
    send_and_capture(8'h03);
    chk("t2_par_odd",  1, 64'(trs[1][39:36]), 64'hF);
    chk("t2_par_even", 2, 64'(trs[2][39:36]), 64'h0);
    chk("t2_done",     1, trd[1][47:0],        64'h080000000000);
    chk("t2_active",   1, 64'(tra[1][44:0]),   64'h0FFFFFFFFFFF);

    // 7 data bits, 2 stop bits, 0x7F: line high from clock 4 to 39.
    send_and_capture(8'h7F);
    chk("t3_line",   3, 64'(trs[3][39:0]), 64'h00FFFFFFFFF0);
    chk("t3_done",   3, trd[3][47:0],       64'h008000000000);
    chk("t3_active", 3, 64'(tra[3][40]),    64'h0);

    // Six writes in six consecutive cycles: the sixth meets a full FIFO.
    n_done0 = 0; n_done1 = 0; n_act0 = 0; n_act1 = 0;
    for (int i = 0; i < 6; i++) begin
      tx_dv   = 1'b1;
      tx_byte = 8'(8'h10 + i * 8'h13);
      tick();
      n_done0 += int'(act_done[0]); n_done1 += int'(act_done[1]);
      n_act0  += int'(act_act[0]);  n_act1  += int'(act_act[1]);
    end
    tx_dv = 1'b0;
    chk("t4_count_full", 0, 64'(act_cnt[0]), 64'd4);
    chk("t4_ready_low",  0, 64'(act_rdy[0]), 64'd0);
    for (int i = 0; i < 260; i++) begin
      tick();
      n_done0 += int'(act_done[0]); n_done1 += int'(act_done[1]);
      n_act0  += int'(act_act[0]);  n_act1  += int'(act_act[1]);
    end
    chk("t4_frames",     0, 64'(n_done0), 64'd5);
    chk("t4_active_clk", 0, 64'(n_act0),  64'd200);
    chk("t4_frames",     1, 64'(n_done1), 64'd5);
    chk("t4_active_clk", 1, 64'(n_act1),  64'd220);

    // Reset in the middle of the data bits with two words still queued.
    for (int i = 0; i < 3; i++) begin
      tx_dv   = 1'b1;
      tx_byte = 8'(8'h00 + i);
      tick();
    end
    tx_dv = 1'b0;
    repeat (10) tick();
    chk("t5_count_pre", 0, 64'(act_cnt[0]), 64'd2);
    chk("t5_line_pre",  0, 64'(act_ser[0]), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("t5_serial", 0, 64'(act_ser[0]),  64'd1);
    chk("t5_count",  0, 64'(act_cnt[0]),  64'd0);
    chk("t5_ready",  0, 64'(act_rdy[0]),  64'd1);
    chk("t5_active", 0, 64'(act_act[0]),  64'd0);
    chk("t5_done",   0, 64'(act_done[0]), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    n_done0 = 0; n_act0 = 0; n_hi0 = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_done0 += int'(act_done[0]);
      n_act0  += int'(act_act[0]);
      n_hi0   += int'(act_ser[0]);
    end
    chk("t5_no_done",   0, 64'(n_done0), 64'd0);
    chk("t5_no_active", 0, 64'(n_act0),  64'd0);
    chk("t5_line_high", 0, 64'(n_hi0),   64'd60);

    // Write coinciding with a pop: dropped when full, absorbed at count 2.
    for (int i = 0; i < 5; i++) begin
      tx_dv   = 1'b1;
      tx_byte = 8'(8'h31 + i);
      tick();
    end
    tx_dv = 1'b0;
    wait_done0(100, ok);
    chk("t6_wait1", 0, 64'(ok), 64'd1);
    chk("t6_full",  0, 64'(act_cnt[0]), 64'd4);
    chk("t6_ready", 0, 64'(act_rdy[0]), 64'd0);
    tx_dv   = 1'b1;
    tx_byte = 8'hA5;
    tick();
    tx_dv = 1'b0;
    chk("t6_dropped", 0, 64'(act_cnt[0]), 64'd3);
    wait_done0(100, ok);
    chk("t6_wait2", 0, 64'(ok), 64'd1);
    wait_done0(100, ok);
    chk("t6_wait3", 0, 64'(ok), 64'd1);
    chk("t6_pre2",  0, 64'(act_cnt[0]), 64'd2);
    tx_dv   = 1'b1;
    tx_byte = 8'h5A;
    tick();
    tx_dv = 1'b0;
    chk("t6_hold2", 0, 64'(act_cnt[0]), 64'd2);

    repeat (400) tick();
    chk("end_idle", 0, 64'(act_act), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a small transmit FIFO.
- Frame format is configurable: data width, parity mode and stop-bit count.
- Host logic can queue several bytes and the serialiser sends them back-to-back with no gap.
- Sits between CPU-side peripheral registers and the board TX pin; single clock domain.

Parameters:
CLKS_PER_BIT, 87, clocks per serial bit (i_Clock freq / baud); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..64

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Tx_DV  in  1  write strobe; pushes i_Tx_Byte when o_Tx_Ready=1
i_Tx_Byte  in  DATA_BITS  data word to queue
o_Tx_Ready  out  1  FIFO not full
o_Fifo_Count  out  clog2(FIFO_DEPTH+1)  words currently queued (excluding frame in flight)
o_Tx_Active  out  1  frame in progress
o_Tx_Serial  out  1  serial line, idle high
o_Tx_Done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async, takes effect immediately, also mid-frame):
  - FIFO flushed; o_Fifo_Count=0, o_Tx_Ready=1.
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, FSM=IDLE.
  - A partially sent frame is abandoned; no Done pulse is issued.
- FIFO write:
  - Push when i_Tx_DV && o_Tx_Ready.
  - i_Tx_DV while full is silently dropped: no overwrite, count unchanged.
  - Push and pop in the same cycle leaves the count unchanged.
  - o_Tx_Ready = (count < FIFO_DEPTH), registered-count based.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - Line = 1.
  - If FIFO non-empty: pop head into shift register, set o_Tx_Active=1, go to START.
- Latency: a write at cycle N into an empty FIFO with FSM idle gives pop at N+1 and o_Tx_Serial=0 from N+2.
- START: line = 0 for exactly CLKS_PER_BIT clocks.
- DATA:
  - DATA_BITS bits, LSB first, each held CLKS_PER_BIT clocks.
  - Bit index runs 0..DATA_BITS-1.
- PARITY (skipped when PARITY=0):
  - One bit period.
  - Odd: total ones in data+parity is odd. Even: total ones is even.
  - Parity is computed from the popped word, not from live input.
- STOP: line = 1 for STOP_BITS*CLKS_PER_BIT clocks. In the last clock of the stop period:
  - o_Tx_Done=1 for exactly one cycle.
  - If FIFO non-empty: pop and go directly to START, keeping o_Tx_Active=1. Line start bit follows the final stop clock with zero extra idle clocks.
  - Otherwise: go to IDLE with o_Tx_Active=0.
- Bit timing counter is clog2(CLKS_PER_BIT) wide, counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit boundary.
- Frame length on line: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks, exact.
- Unused upper bits do not exist: i_Tx_Byte width equals DATA_BITS.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are derived from a count register, not pointer equality.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, write 0x55 -> line: 4 clocks 0, then 1,0,1,0,1,0,1,0 (LSB first, 4 clocks each), 4 clocks 1; o_Tx_Done pulses once at clock 40 of frame; Active low afterwards.
2. PARITY=1 (odd), write 0x03 -> parity bit 1; PARITY=2 (even), write 0x03 -> parity bit 0; frame = 44 clocks at CLKS_PER_BIT=4.
3. STOP_BITS=2, DATA_BITS=7, write 0x7F -> seven 1 data bits, stop high for 8 clocks; Done at end of second stop bit.
4. FIFO_DEPTH=4: write 6 words in 6 consecutive cycles while idle -> first popped after 1 cycle, next 4 queued, 6th dropped (Ready low when count=4); exactly 5 frames sent back-to-back, no idle clocks between frames, 5 Done pulses.
5. Reset asserted mid-DATA of frame 1 with 2 words queued -> o_Tx_Serial=1 immediately, count=0, Ready=1, no Done pulse; after release, no frames sent until new write.
6. Write issued in the same cycle as a pop from a full FIFO -> write dropped (Ready was 0); write in the same cycle as a pop at count=2 -> count stays 2.
